// File: rtl/instr_fetch.sv
// Program counter, instruction register and Fetch/Read/Execute phase counter.
// Feeds decoded instruction fields to the processor control FSM.

package opcodes;
  typedef enum logic [1:0] {
    PcInc  = 2'd0,
    PcWait = 2'd1,
    PcJmp  = 2'd2
  } PcSel_t;

  typedef enum logic [4:0] {
    NOOP  = 5'h00,
    ADD   = 5'h01,
    ADDI  = 5'h02,
    SUB   = 5'h03,
    LDI   = 5'h04,
    LD    = 5'h05,
    ST    = 5'h06,
    JMP   = 5'h07,
    JZ    = 5'h08,
    WAIT0 = 5'h09,
    WAIT1 = 5'h0A
  } opcodes_t;
endpackage

module instr_fetch
  import opcodes::*;
#(
  parameter int                  PC_WIDTH    = 8,
  parameter int                  INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = 'h00
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  PcSel_t                 PcSel,
  input  logic [PC_WIDTH-1:0]    JumpTarget,
  input  logic [INSTR_WIDTH-1:0] ProgData,
  output logic [PC_WIDTH-1:0]    ProgAddress,
  output logic [PC_WIDTH-1:0]    Pc,
  output opcodes_t               OpCode,
  output logic [2:0]             RegIdx,
  output logic [7:0]             Immediate,
  output logic [1:0]             Phase,
  output logic [15:0]            RetireCount,
  output logic                   SeqError
);

  // The field map below is hard-wired to a 16-bit word with a 5-bit opcode.
  if ($bits(opcodes_t) != 5 || INSTR_WIDTH != 16) begin : g_bad_config
    $fatal(1, "instr_fetch: needs 5-bit opcodes_t and INSTR_WIDTH == 16");
  end

  typedef enum logic [1:0] {
    PH_FETCH = 2'd0,
    PH_READ  = 2'd1,
    PH_EXEC  = 2'd2
  } phase_t;

  phase_t                 phase_q, phase_d;
  logic [PC_WIDTH-1:0]    pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] ir_q, ir_d;
  logic [15:0]            retire_q, retire_d;
  logic                   seq_err_q, seq_err_d;
  logic                   sel_is_wait;

  assign sel_is_wait = (PcSel == PcWait);

  always_comb begin
    phase_d   = PH_FETCH;
    pc_d      = pc_q;
    ir_d      = ir_q;
    retire_d  = retire_q;
    seq_err_d = seq_err_q;

    case (phase_q)
      PH_FETCH: phase_d = PH_READ;
      PH_READ: begin
        phase_d = PH_EXEC;
        ir_d    = ProgData;
      end
      PH_EXEC: begin
        phase_d = PH_FETCH;
        // Unused PcSel encodings advance like PcInc so the program never stalls.
        case (PcSel)
          PcWait:  pc_d = pc_q;
          PcJmp:   pc_d = JumpTarget;
          default: pc_d = pc_q + PC_WIDTH'(1);
        endcase
        if (!sel_is_wait && retire_q != 16'hFFFF) begin
          retire_d = retire_q + 16'd1;
        end
      end
      default: phase_d = PH_FETCH;
    endcase

    if (phase_q != PH_EXEC && !sel_is_wait) begin
      seq_err_d = 1'b1;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      phase_q   <= PH_FETCH;
      pc_q      <= RESET_PC;
      ir_q      <= '0;
      retire_q  <= '0;
      seq_err_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      retire_q  <= retire_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign ProgAddress = pc_q;
  assign Pc          = pc_q;
  assign OpCode      = opcodes_t'(ir_q[15:11]);
  assign RegIdx      = ir_q[10:8];
  assign Immediate   = ir_q[7:0];
  assign Phase       = phase_q;
  assign RetireCount = retire_q;
  assign SeqError    = seq_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: a synchronous ROM model feeds ProgData and
// each task checks phase sequencing, PC update, decode and error flag.

module tb_instr_fetch;
  import opcodes::*;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  PcSel_t      PcSel = PcWait;
  logic [7:0]  JumpTarget = 8'h00;
  logic [15:0] ProgData;
  logic [7:0]  ProgAddress;
  logic [7:0]  Pc;
  opcodes_t    OpCode;
  logic [2:0]  RegIdx;
  logic [7:0]  Immediate;
  logic [1:0]  Phase;
  logic [15:0] RetireCount;
  logic        SeqError;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] rom [0:255];

  instr_fetch #(.PC_WIDTH(8), .INSTR_WIDTH(16), .RESET_PC(8'h00)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .PcSel      (PcSel),
    .JumpTarget (JumpTarget),
    .ProgData   (ProgData),
    .ProgAddress(ProgAddress),
    .Pc         (Pc),
    .OpCode     (OpCode),
    .RegIdx     (RegIdx),
    .Immediate  (Immediate),
    .Phase      (Phase),
    .RetireCount(RetireCount),
    .SeqError   (SeqError)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) ProgData <= rom[ProgAddress];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // One clock with the given selection, then return to the idle PcWait.
  task automatic tick(input PcSel_t sel, input logic [7:0] tgt);
    PcSel      = sel;
    JumpTarget = tgt;
    @(posedge Clock);
    #1;
    PcSel      = PcWait;
    JumpTarget = 8'h00;
  endtask

  task automatic test_reset;
    Reset = 1'b1;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
    n_checks++; if (Pc !== 8'h00) begin n_fail++; $display("FAIL reset_pc: got %h expected 00", Pc); end
    n_checks++; if (ProgAddress !== 8'h00) begin n_fail++; $display("FAIL reset_addr: got %h expected 00", ProgAddress); end
    n_checks++; if (Phase !== 2'd0) begin n_fail++; $display("FAIL reset_phase: got %0d expected 0", Phase); end
    n_checks++; if (OpCode !== NOOP) begin n_fail++; $display("FAIL reset_opcode: got %h expected %h", OpCode, NOOP); end
    n_checks++; if (SeqError !== 1'b0) begin n_fail++; $display("FAIL reset_seqerr: got %b expected 0", SeqError); end
    n_checks++; if (RetireCount !== 16'h0000) begin n_fail++; $display("FAIL reset_retire: got %h expected 0000", RetireCount); end
    $display("reset released: Pc=%h Phase=%0d", Pc, Phase);
  endtask

  task automatic test_fetch_addi;
    tick(PcWait, 8'h00);
    n_checks++; if (Phase !== 2'd1) begin n_fail++; $display("FAIL addi_phase_read: got %0d expected 1", Phase); end
    n_checks++; if (OpCode !== NOOP) begin n_fail++; $display("FAIL addi_early_ir: got %h expected %h", OpCode, NOOP); end
    tick(PcWait, 8'h00);
    n_checks++; if (Phase !== 2'd2) begin n_fail++; $display("FAIL addi_phase_exec: got %0d expected 2", Phase); end
    n_checks++; if (OpCode !== ADDI) begin n_fail++; $display("FAIL addi_opcode: got %h expected %h", OpCode, ADDI); end
    n_checks++; if (Immediate !== 8'h05) begin n_fail++; $display("FAIL addi_imm: got %h expected 05", Immediate); end
    n_checks++; if (RegIdx !== 3'd1) begin n_fail++; $display("FAIL addi_reg: got %0d expected 1", RegIdx); end
    n_checks++; if (Pc !== 8'h00) begin n_fail++; $display("FAIL addi_pc_hold: got %h expected 00", Pc); end
    tick(PcInc, 8'h00);
    n_checks++; if (Pc !== 8'h01) begin n_fail++; $display("FAIL addi_pc_inc: got %h expected 01", Pc); end
    n_checks++; if (RetireCount !== 16'd1) begin n_fail++; $display("FAIL addi_retire: got %0d expected 1", RetireCount); end
    n_checks++; if (OpCode !== ADDI) begin n_fail++; $display("FAIL addi_opcode_stable: got %h expected %h", OpCode, ADDI); end
    n_checks++; if (Phase !== 2'd0) begin n_fail++; $display("FAIL addi_phase_wrap: got %0d expected 0", Phase); end
    $display("ADDI retired: Pc=%h RetireCount=%0d", Pc, RetireCount);
  endtask

  task automatic test_jump;
    tick(PcWait, 8'h00);
    tick(PcWait, 8'h00);
    n_checks++; if (OpCode !== JMP) begin n_fail++; $display("FAIL jmp_opcode: got %h expected %h", OpCode, JMP); end
    n_checks++; if (Immediate !== 8'h3C) begin n_fail++; $display("FAIL jmp_imm: got %h expected 3C", Immediate); end
    tick(PcJmp, 8'h3C);
    n_checks++; if (Pc !== 8'h3C) begin n_fail++; $display("FAIL jmp_pc: got %h expected 3C", Pc); end
    n_checks++; if (ProgAddress !== 8'h3C) begin n_fail++; $display("FAIL jmp_addr: got %h expected 3C", ProgAddress); end
    n_checks++; if (RetireCount !== 16'd2) begin n_fail++; $display("FAIL jmp_retire: got %0d expected 2", RetireCount); end
    $display("JMP taken: Pc=%h", Pc);
  endtask

  task automatic test_wrap;
    tick(PcWait, 8'h00);
    tick(PcWait, 8'h00);
    tick(PcJmp, 8'hFF);
    n_checks++; if (Pc !== 8'hFF) begin n_fail++; $display("FAIL wrap_setup_pc: got %h expected FF", Pc); end
    tick(PcWait, 8'h00);
    tick(PcWait, 8'h00);
    n_checks++; if (OpCode !== LDI) begin n_fail++; $display("FAIL wrap_opcode: got %h expected %h", OpCode, LDI); end
    n_checks++; if (RegIdx !== 3'd2) begin n_fail++; $display("FAIL wrap_reg: got %0d expected 2", RegIdx); end
    tick(PcInc, 8'h00);
    n_checks++; if (Pc !== 8'h00) begin n_fail++; $display("FAIL wrap_pc: got %h expected 00", Pc); end
    n_checks++; if (RetireCount !== 16'd4) begin n_fail++; $display("FAIL wrap_retire: got %0d expected 4", RetireCount); end
    $display("PC wrapped: Pc=%h", Pc);
  endtask

  task automatic test_wait;
    rom[8'h00] = 16'h4811;  // WAIT0, imm 11
    for (int p = 0; p < 4; p++) begin
      tick(PcWait, 8'h00);
      tick(PcWait, 8'h00);
      n_checks++; if (OpCode !== WAIT0) begin n_fail++; $display("FAIL wait_opcode[%0d]: got %h expected %h", p, OpCode, WAIT0); end
      n_checks++; if (Immediate !== 8'h11) begin n_fail++; $display("FAIL wait_imm[%0d]: got %h expected 11", p, Immediate); end
      tick(PcWait, 8'h00);
      n_checks++; if (Pc !== 8'h00) begin n_fail++; $display("FAIL wait_pc[%0d]: got %h expected 00", p, Pc); end
      n_checks++; if (RetireCount !== 16'd4) begin n_fail++; $display("FAIL wait_retire[%0d]: got %0d expected 4", p, RetireCount); end
      $display("WAIT period %0d: Pc=%h RetireCount=%0d", p, Pc, RetireCount);
    end
    n_checks++; if (SeqError !== 1'b0) begin n_fail++; $display("FAIL wait_seqerr: got %b expected 0", SeqError); end
  endtask

  task automatic test_reset_in_read;
    tick(PcWait, 8'h00);
    tick(PcWait, 8'h00);
    tick(PcJmp, 8'h10);
    tick(PcWait, 8'h00);
    n_checks++; if (Pc !== 8'h10 || Phase !== 2'd1) begin n_fail++; $display("FAIL rst_setup: got Pc=%h Phase=%0d expected Pc=10 Phase=1", Pc, Phase); end
    Reset = 1'b1;
    #1;
    n_checks++; if (Pc !== 8'h00) begin n_fail++; $display("FAIL rst_async_pc: got %h expected 00", Pc); end
    n_checks++; if (Phase !== 2'd0) begin n_fail++; $display("FAIL rst_async_phase: got %0d expected 0", Phase); end
    n_checks++; if (OpCode !== NOOP || Immediate !== 8'h00) begin n_fail++; $display("FAIL rst_async_ir: got %h/%h expected %h/00", OpCode, Immediate, NOOP); end
    #2;
    Reset = 1'b0;
    @(posedge Clock);
    #1;
    n_checks++; if (OpCode !== NOOP || Immediate !== 8'h00) begin n_fail++; $display("FAIL rst_no_inflight_load: got %h/%h expected %h/00", OpCode, Immediate, NOOP); end
    n_checks++; if (Phase !== 2'd1) begin n_fail++; $display("FAIL rst_phase_after: got %0d expected 1", Phase); end
    tick(PcWait, 8'h00);
    n_checks++; if (OpCode !== WAIT0) begin n_fail++; $display("FAIL rst_refetch: got %h expected %h", OpCode, WAIT0); end
    tick(PcInc, 8'h00);
    n_checks++; if (Pc !== 8'h01 || RetireCount !== 16'd1) begin n_fail++; $display("FAIL rst_resume: got Pc=%h Retire=%0d expected Pc=01 Retire=1", Pc, RetireCount); end
    $display("reset mid-Read recovered: Pc=%h", Pc);
  endtask

  task automatic test_seq_error;
    Reset = 1'b1;
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    tick(PcInc, 8'h00);
    n_checks++; if (SeqError !== 1'b1) begin n_fail++; $display("FAIL seq_set: got %b expected 1", SeqError); end
    n_checks++; if (Pc !== 8'h00) begin n_fail++; $display("FAIL seq_fetch_pc: got %h expected 00", Pc); end
    tick(PcJmp, 8'h55);
    n_checks++; if (Pc !== 8'h00) begin n_fail++; $display("FAIL seq_read_pc: got %h expected 00", Pc); end
    tick(PcWait, 8'h00);
    n_checks++; if (RetireCount !== 16'd0) begin n_fail++; $display("FAIL seq_retire: got %0d expected 0", RetireCount); end
    for (int i = 0; i < 5; i++) tick(PcWait, 8'h00);
    tick(PcInc, 8'h00);
    n_checks++; if (Pc !== 8'h01) begin n_fail++; $display("FAIL seq_pc_later: got %h expected 01", Pc); end
    n_checks++; if (SeqError !== 1'b1) begin n_fail++; $display("FAIL seq_sticky: got %b expected 1", SeqError); end
    Reset = 1'b1;
    #1;
    n_checks++; if (SeqError !== 1'b0) begin n_fail++; $display("FAIL seq_clear: got %b expected 0", SeqError); end
    @(posedge Clock);
    #1;
    Reset = 1'b0;
    $display("SeqError cleared by reset: SeqError=%b", SeqError);
  endtask

  task automatic test_other_sel;
    tick(PcWait, 8'h00);
    tick(PcWait, 8'h00);
    tick(PcSel_t'(2'b11), 8'h77);
    n_checks++; if (Pc !== 8'h01) begin n_fail++; $display("FAIL other_sel_pc: got %h expected 01", Pc); end
    n_checks++; if (RetireCount !== 16'd1) begin n_fail++; $display("FAIL other_sel_retire: got %0d expected 1", RetireCount); end
    n_checks++; if (SeqError !== 1'b0) begin n_fail++; $display("FAIL other_sel_seqerr: got %b expected 0", SeqError); end
    $display("PcSel=3 treated as increment: Pc=%h", Pc);
  endtask

  initial begin
    for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
    rom[8'h00] = 16'h1105;  // ADDI r1, 05
    rom[8'h01] = 16'h383C;  // JMP 3C
    rom[8'h3C] = 16'h38FF;  // JMP FF
    rom[8'hFF] = 16'h22A5;  // LDI r2, A5
    rom[8'h10] = 16'h1B77;  // SUB r3, 77

    test_reset();
    test_fetch_addi();
    test_jump();
    test_wrap();
    test_wait();
    test_reset_in_read();
    test_seq_error();
    test_other_sel();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
